sudoku_slot_sched: RTL and testbench
====================================

// Module: sudoku_slot_sched
// PURPOSE
//  Scheduler in front of sudoku_core. Round-robin arbitrates NUM_REQ puzzle requesters into the
//  core's NUM_SLOTS recirculating pipeline slots and tracks owner/iteration count per slot.
//  Captures each finished puzzle into a 1-entry response buffer tagged with owner id and status.
//  Sits between the puzzle source fabric and one sudoku_core instance; drives core go/avail/puzzle_in.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  REQ_W      2   width of requester id, clog2(NUM_REQ)
//  NUM_SLOTS  6   core pipeline slots; equal to core NUM_PIPE_STGS
//  SLOT_W     3   width of slot pointer, clog2(NUM_SLOTS)
//  ITER_W     8   width of per-slot pass counter (saturating)
// PORTS
//  clk          in   1            clock
//  rst          in   1            reset, asynchronous, active-high
//  en           in   1            accept new requests; first assertion starts the core
//  req_valid    in   NUM_REQ      per-requester puzzle valid
//  req_puzzle   in   NUM_REQ*324  per-requester puzzle, requester i at [i*324 +: 324], core hex format
//  req_ready    out  NUM_REQ      one-hot grant; puzzle i consumed this cycle
//  rsp_valid    out  1            response buffer full
//  rsp_ready    in   1            consumer takes response when rsp_valid&&rsp_ready
//  rsp_puzzle   out  324          finished puzzle (core puzzle_out)
//  rsp_id       out  REQ_W        owner requester
//  rsp_solved   out  1            1 = no zero nibble in rsp_puzzle
//  rsp_iter     out  ITER_W       passes the puzzle made through the core
//  core_go      out  1            to core go
//  core_avail   out  1            to core puzzle_avail
//  core_pz_in   out  324          to core puzzle_in
//  core_pz_out  in   324          from core puzzle_out
//  core_read    in   1            from core read_puzzle
//  core_done    in   1            from core done_puzzle
//  stat_solved  out  16           solved-response counter (see CONFIGURATION)
//  stat_stuck   out  16           unsolved-response counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, slot table invalid, slot_ptr=0, rr_ptr=0, counters 0.
//  FSM: IDLE -(en)-> RUN -(!en)-> DRAIN -(en)-> RUN. DRAIN with all slots invalid stays DRAIN (quiet).
//   core_go registered: 0 in IDLE, 1 from cycle after leaving IDLE, never deasserted again until rst
//   (core pipeline free-runs; go must not gap).
//  slot_ptr: +1 every cycle core_go=1, wraps NUM_SLOTS-1 -> 0; mirrors core end-of-pipe slot.
//  core_avail = core_go && !rsp_valid (registered-state only, no combinational path from rsp_ready).
//  Load: when core_read=1, slot[slot_ptr] is (re)loaded this cycle:
//   - if state==RUN and any req_valid: round-robin pick from rr_ptr; req_ready[g]=1 (combinational),
//     core_pz_in=req_puzzle[g]; slot <= {valid=1, id=g, iter=0}; rr_ptr <= g+1 mod NUM_REQ.
//   - else core_pz_in = 0 (blank), slot <= invalid. req_ready = 0 whenever core_read=0.
//  Retire: core_done=1 (always coincident with core_read) for a valid slot -> next cycle rsp_valid=1,
//   rsp_puzzle=core_pz_out, rsp_id/iter from slot, rsp_solved computed from core_pz_out.
//   Done on an invalid slot: result discarded, no rsp_valid.
//  Pass counting: slot_ptr reaching a valid slot with core_done=0 -> slot iter +1, saturate at all-ones.
//  Response buffer: cleared on rsp_valid&&rsp_ready; core_avail low while full, so no overwrite
//   possible; core keeps recirculating (iter keeps counting).
//  Simultaneous retire and load on same slot: retire uses old slot fields, load writes new ones.
//  en drop mid-run: in-flight puzzles still retire; no new grants. rst mid-run: all state dropped,
//   in-flight puzzles lost, core_go returns 0.
// CONFIGURATION
//  SUDOKU_SCHED_STATS_EN defined: stat_solved/stat_stuck +1 on each accepted response
//   (rsp_valid&&rsp_ready) per rsp_solved, saturate at 16'hFFFF, cleared by rst.
//  Undefined: no counter flops; stat_solved and stat_stuck tied to 0.
// TESTING
//  T1 rst, en=1, req0 valid with solved puzzle -> req_ready[0] on first core_read; rsp_valid with
//     rsp_id=0, rsp_solved=1, rsp_iter=0; stat_solved=1 (STATS_EN).
//  T2 all 4 req_valid held, rr_ptr=0 -> grants in order 0,1,2,3,0,1 on six consecutive core_read.
//  T3 rsp_ready=0 after first response -> core_avail=0, no second rsp, iter of waiting slots rises;
//     rsp_ready=1 -> buffer drains, next response follows.
//  T4 puzzle with unsolvable zero cell -> rsp_solved=0, stat_stuck=1; rsp_iter equals passes counted.
//  T5 en=0 with 3 slots in flight -> no req_ready, 3 responses then silence; core_go stays 1.
//  T6 rst asserted with full slots and rsp_valid=1 -> all outputs 0 same cycle, restart clean on en.

Source files
------------

// File: rtl/sudoku_slot_sched_if.sv
// sudoku_slot_sched_if: requester, response, core-side and statistics signals of the slot
// scheduler. The slave modport is the scheduler; the master modport is its environment
// (puzzle source fabric, response consumer and the sudoku_core instance).
interface sudoku_slot_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned REQ_W   = 2,
  parameter int unsigned ITER_W  = 8,
  parameter int unsigned PZ_W    = 324
) ();
  logic                    en;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*PZ_W-1:0] req_puzzle;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [PZ_W-1:0]         rsp_puzzle;
  logic [REQ_W-1:0]        rsp_id;
  logic                    rsp_solved;
  logic [ITER_W-1:0]       rsp_iter;
  logic                    core_go;
  logic                    core_avail;
  logic [PZ_W-1:0]         core_pz_in;
  logic [PZ_W-1:0]         core_pz_out;
  logic                    core_read;
  logic                    core_done;
  logic [15:0]             stat_solved;
  logic [15:0]             stat_stuck;

  modport master (
    output en, req_valid, req_puzzle, rsp_ready, core_pz_out, core_read, core_done,
    input  req_ready, rsp_valid, rsp_puzzle, rsp_id, rsp_solved, rsp_iter,
    input  core_go, core_avail, core_pz_in, stat_solved, stat_stuck
  );

  modport slave (
    input  en, req_valid, req_puzzle, rsp_ready, core_pz_out, core_read, core_done,
    output req_ready, rsp_valid, rsp_puzzle, rsp_id, rsp_solved, rsp_iter,
    output core_go, core_avail, core_pz_in, stat_solved, stat_stuck
  );
endinterface

// File: rtl/sudoku_slot_sched.sv
// sudoku_slot_sched: round-robin arbiter feeding puzzles into the recirculating slots of one
// sudoku_core, with a per-slot owner/pass-count table and a single-entry response buffer.
// Optional response statistics counters are built when SUDOKU_SCHED_STATS_EN is defined;
// otherwise stat_solved/stat_stuck are tied to zero.
module sudoku_slot_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned REQ_W     = 2,
  parameter int unsigned NUM_SLOTS = 6,
  parameter int unsigned SLOT_W    = 3,
  parameter int unsigned ITER_W    = 8
) (
  input logic                clk,
  input logic                rst,
  sudoku_slot_sched_if.slave bus
);
  localparam int unsigned PZ_W      = 324;
  localparam int unsigned NUM_CELLS = 81;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic                 core_go_q, core_go_d;
  logic [SLOT_W-1:0]    slot_ptr_q, slot_ptr_d;
  logic [REQ_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_SLOTS-1:0] slot_valid_q, slot_valid_d;
  logic [REQ_W-1:0]     slot_id_q [NUM_SLOTS];
  logic [REQ_W-1:0]     slot_id_d [NUM_SLOTS];
  logic [ITER_W-1:0]    slot_iter_q [NUM_SLOTS];
  logic [ITER_W-1:0]    slot_iter_d [NUM_SLOTS];

  logic                 rsp_valid_q, rsp_valid_d;
  logic [PZ_W-1:0]      rsp_puzzle_q, rsp_puzzle_d;
  logic [REQ_W-1:0]     rsp_id_q, rsp_id_d;
  logic [ITER_W-1:0]    rsp_iter_q, rsp_iter_d;
  logic                 rsp_solved_q, rsp_solved_d;

  logic                 grant_vld;
  logic [REQ_W-1:0]     grant_id;
  logic [REQ_W-1:0]     rr_idx;
  logic                 load_grant;
  logic                 cur_valid;
  logic                 retire;
  logic                 pz_out_solved;
  logic [NUM_REQ-1:0]   req_ready;
  logic [PZ_W-1:0]      core_pz_in;

  // Mode FSM: new grants only in StRun; StDrain lets in-flight puzzles finish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.en)  state_d = StRun;
      StRun:   if (!bus.en) state_d = StDrain;
      StDrain: if (bus.en)  state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // Core go latches on leaving idle and never gaps; slot pointer tracks the core end-of-pipe slot.
  always_comb begin
    core_go_d  = core_go_q | ((state_q == StIdle) & bus.en);
    slot_ptr_d = slot_ptr_q;
    if (core_go_q) begin
      slot_ptr_d = (slot_ptr_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_ptr_q + SLOT_W'(1);
    end
  end

  // Round-robin search starting at rr_ptr for the first valid requester.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    rr_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = REQ_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && bus.req_valid[rr_idx]) begin
        grant_vld = 1'b1;
        grant_id  = rr_idx;
      end
    end
  end

  assign load_grant = bus.core_read & (state_q == StRun) & grant_vld;
  assign cur_valid  = slot_valid_q[slot_ptr_q];
  assign retire     = bus.core_done & cur_valid;

  // Grant strobe and puzzle mux into the core; blank puzzle whenever nothing is granted.
  always_comb begin
    req_ready  = '0;
    core_pz_in = '0;
    rr_ptr_d   = rr_ptr_q;
    if (load_grant) begin
      req_ready[grant_id] = 1'b1;
      rr_ptr_d = (grant_id == REQ_W'(NUM_REQ - 1)) ? '0 : grant_id + REQ_W'(1);
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (load_grant && (grant_id == REQ_W'(k))) begin
        core_pz_in = bus.req_puzzle[k*PZ_W +: PZ_W];
      end
    end
  end

  // Slot table: a core read reloads the slot (load wins); otherwise a visit without done is a pass.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_id_d    = slot_id_q;
    slot_iter_d  = slot_iter_q;
    if (bus.core_read) begin
      slot_valid_d[slot_ptr_q] = load_grant;
      slot_id_d[slot_ptr_q]    = load_grant ? grant_id : '0;
      slot_iter_d[slot_ptr_q]  = '0;
    end else if (core_go_q && cur_valid && !bus.core_done &&
                 (slot_iter_q[slot_ptr_q] != '1)) begin
      slot_iter_d[slot_ptr_q] = slot_iter_q[slot_ptr_q] + ITER_W'(1);
    end
  end

  // A puzzle is solved when none of its 81 cells is still zero.
  always_comb begin
    pz_out_solved = 1'b1;
    for (int unsigned c = 0; c < NUM_CELLS; c++) begin
      if (bus.core_pz_out[c*4 +: 4] == 4'h0) pz_out_solved = 1'b0;
    end
  end

  // Response buffer: pop on handshake, capture on retire using the slot's pre-load fields.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_puzzle_d = rsp_puzzle_q;
    rsp_id_d     = rsp_id_q;
    rsp_iter_d   = rsp_iter_q;
    rsp_solved_d = rsp_solved_q;
    if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
    if (retire) begin
      rsp_valid_d  = 1'b1;
      rsp_puzzle_d = bus.core_pz_out;
      rsp_id_d     = slot_id_q[slot_ptr_q];
      rsp_iter_d   = slot_iter_q[slot_ptr_q];
      rsp_solved_d = pz_out_solved;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      core_go_q    <= 1'b0;
      slot_ptr_q   <= '0;
      rr_ptr_q     <= '0;
      slot_valid_q <= '0;
      slot_id_q    <= '{default: '0};
      slot_iter_q  <= '{default: '0};
      rsp_valid_q  <= 1'b0;
      rsp_puzzle_q <= '0;
      rsp_id_q     <= '0;
      rsp_iter_q   <= '0;
      rsp_solved_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_go_q    <= core_go_d;
      slot_ptr_q   <= slot_ptr_d;
      rr_ptr_q     <= rr_ptr_d;
      slot_valid_q <= slot_valid_d;
      slot_id_q    <= slot_id_d;
      slot_iter_q  <= slot_iter_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_puzzle_q <= rsp_puzzle_d;
      rsp_id_q     <= rsp_id_d;
      rsp_iter_q   <= rsp_iter_d;
      rsp_solved_q <= rsp_solved_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.core_pz_in = core_pz_in;
  assign bus.core_go    = core_go_q;
  // Only registered state here so the consumer's rsp_ready never reaches the core combinationally.
  assign bus.core_avail = core_go_q & ~rsp_valid_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_puzzle = rsp_puzzle_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_iter   = rsp_iter_q;
  assign bus.rsp_solved = rsp_solved_q;

`ifdef SUDOKU_SCHED_STATS_EN
  logic [15:0] stat_solved_q, stat_solved_d;
  logic [15:0] stat_stuck_q, stat_stuck_d;

  // Count accepted responses by outcome, saturating.
  always_comb begin
    stat_solved_d = stat_solved_q;
    stat_stuck_d  = stat_stuck_q;
    if (rsp_valid_q && bus.rsp_ready) begin
      if (rsp_solved_q) begin
        if (stat_solved_q != 16'hFFFF) stat_solved_d = stat_solved_q + 16'd1;
      end else begin
        if (stat_stuck_q != 16'hFFFF) stat_stuck_d = stat_stuck_q + 16'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_solved_q <= '0;
      stat_stuck_q  <= '0;
    end else begin
      stat_solved_q <= stat_solved_d;
      stat_stuck_q  <= stat_stuck_d;
    end
  end

  assign bus.stat_solved = stat_solved_q;
  assign bus.stat_stuck  = stat_stuck_q;
`else
  assign bus.stat_solved = '0;
  assign bus.stat_stuck  = '0;
`endif

endmodule

// File: tb/tb_sudoku_slot_sched.sv
// tb_sudoku_slot_sched: table-driven round-robin vectors, then randomized traffic against a
// behavioural scheduler model plus a simple recirculating core model, with an async reset mid-run.
`timescale 1ns/1ps
module tb_sudoku_slot_sched;
  localparam int NR = 4;
  localparam int RW = 2;
  localparam int NS = 6;
  localparam int PW = 324;
  localparam int ITER_MAX = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sudoku_slot_sched_if bus ();
  sudoku_slot_sched dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  // Scheduler reference state.
  bit             started, en_prev, full, rsol;
  int             ptr, rr, rid, rit, st_sol, st_stk;
  bit             sv [NS];
  int             sid [NS];
  int             sit [NS];
  logic [PW-1:0]  rpz;
  // Core model state.
  bit             co [NS];
  int             cleft [NS];
  logic [PW-1:0]  cpz [NS];

  typedef struct {
    logic [NR-1:0] valid;
    bit            read;
    logic [NR-1:0] exp_ready;
  } vec_t;
  vec_t vt [14];
  logic [PW-1:0] tpz [NR];

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_puzzle();
    logic [PW-1:0] p;
    for (int i = 0; i < 81; i++) p[i*4 +: 4] = 4'($urandom_range(1, 9));
    if ($urandom_range(0, 2) == 0) p[$urandom_range(0, 80)*4 +: 4] = 4'h0;
    return p;
  endfunction

  function automatic bit solved_of(input logic [PW-1:0] p);
    for (int i = 0; i < 81; i++) if (p[i*4 +: 4] == 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    started = 0; en_prev = 0; full = 0; rsol = 0;
    ptr = 0; rr = 0; rid = 0; rit = 0; rpz = '0; st_sol = 0; st_stk = 0;
    for (int s = 0; s < NS; s++) begin
      sv[s] = 0; sid[s] = 0; sit[s] = 0; co[s] = 0; cleft[s] = 0; cpz[s] = '0;
    end
  endtask

  task automatic drive_idle();
    bus.en = 0; bus.req_valid = '0; bus.req_puzzle = '0; bus.rsp_ready = 0;
    bus.core_pz_out = '0; bus.core_read = 0; bus.core_done = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " core_go"}, bus.core_go, '0);
    chk({tag, " core_avail"}, bus.core_avail, '0);
    chk({tag, " req_ready"}, bus.req_ready, '0);
    chk({tag, " core_pz_in"}, bus.core_pz_in, '0);
    chk({tag, " rsp_valid"}, bus.rsp_valid, '0);
    chk({tag, " rsp_puzzle"}, bus.rsp_puzzle, '0);
    chk({tag, " rsp_id"}, bus.rsp_id, '0);
    chk({tag, " rsp_iter"}, bus.rsp_iter, '0);
    chk({tag, " rsp_solved"}, bus.rsp_solved, '0);
    chk({tag, " stat_solved"}, bus.stat_solved, '0);
    chk({tag, " stat_stuck"}, bus.stat_stuck, '0);
  endtask

  // One random cycle: entered at posedge+1, leaves at the next posedge+1.
  task automatic step(input int en_pct, input int rdy_pct);
    bit            exp_go, exp_avail, rd, dn, en_v;
    int            s, g, idx;
    logic [PW-1:0] pzo, exp_pzin;
    logic [NR-1:0] exp_ready;
    en_v = ($urandom_range(0, 99) < en_pct);
    bus.en = en_v;
    bus.req_valid = NR'($urandom);
    for (int k = 0; k < NR; k++) bus.req_puzzle[k*PW +: PW] = rand_puzzle();
    bus.rsp_ready = ($urandom_range(0, 99) < rdy_pct);
    exp_go = started;
    exp_avail = started && !full;
    s = ptr; rd = 0; dn = 0; pzo = rand_puzzle();
    if (exp_go) begin
      if (co[s] && cleft[s] == 0 && exp_avail) begin
        rd = 1; dn = 1; pzo = cpz[s];
      end else if (!co[s] && exp_avail) begin
        rd = 1; dn = ($urandom_range(0, 7) == 0);  // spurious done on an empty slot
      end
    end
    bus.core_read = rd; bus.core_done = dn; bus.core_pz_out = pzo;
    #3;
    g = -1;
    if (rd && started && en_prev) begin
      for (int k = 0; k < NR; k++) begin
        idx = (rr + k) % NR;
        if (g < 0 && bus.req_valid[RW'(idx)]) g = idx;
      end
    end
    exp_ready = '0; exp_pzin = '0;
    if (g >= 0) begin
      exp_ready[RW'(g)] = 1'b1;
      exp_pzin = bus.req_puzzle[g*PW +: PW];
    end
    chk("core_go", bus.core_go, exp_go);
    chk("core_avail", bus.core_avail, exp_avail);
    chk("req_ready", bus.req_ready, exp_ready);
    chk("core_pz_in", bus.core_pz_in, exp_pzin);
    chk("rsp_valid", bus.rsp_valid, full);
    if (full) begin
      chk("rsp_id", bus.rsp_id, rid);
      chk("rsp_iter", bus.rsp_iter, rit);
      chk("rsp_solved", bus.rsp_solved, rsol);
      chk("rsp_puzzle", bus.rsp_puzzle, rpz);
    end
`ifdef SUDOKU_SCHED_STATS_EN
    chk("stat_solved", bus.stat_solved, st_sol);
    chk("stat_stuck", bus.stat_stuck, st_stk);
`else
    chk("stat_solved", bus.stat_solved, '0);
    chk("stat_stuck", bus.stat_stuck, '0);
`endif
    // Advance the reference by one clock.
    if (full && bus.rsp_ready) begin
      full = 0;
      if (rsol) st_sol = (st_sol < 65535) ? st_sol + 1 : 65535;
      else      st_stk = (st_stk < 65535) ? st_stk + 1 : 65535;
    end
    if (dn && sv[s]) begin
      full = 1; rpz = pzo; rid = sid[s]; rit = sit[s]; rsol = solved_of(pzo);
    end
    if (rd) begin
      sv[s] = (g >= 0); sid[s] = (g >= 0) ? g : 0; sit[s] = 0;
      if (g >= 0) rr = (g + 1) % NR;
    end else if (exp_go && sv[s] && !dn) begin
      sit[s] = (sit[s] < ITER_MAX) ? sit[s] + 1 : ITER_MAX;
    end
    if (exp_go) begin
      if (rd) begin
        co[s] = (exp_pzin != '0); cpz[s] = exp_pzin; cleft[s] = $urandom_range(0, 4);
      end else if (co[s] && cleft[s] > 0) begin
        cleft[s]--;
      end
      ptr = (ptr + 1) % NS;
    end
    if (en_v) started = 1;
    en_prev = en_v;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [PW-1:0] exp_pz;
    vt[0]  = '{4'b1111, 1'b1, 4'b0001};
    vt[1]  = '{4'b1111, 1'b1, 4'b0010};
    vt[2]  = '{4'b1111, 1'b0, 4'b0000};
    vt[3]  = '{4'b1111, 1'b1, 4'b0100};
    vt[4]  = '{4'b1111, 1'b1, 4'b1000};
    vt[5]  = '{4'b1111, 1'b1, 4'b0001};
    vt[6]  = '{4'b1001, 1'b1, 4'b1000};
    vt[7]  = '{4'b0110, 1'b1, 4'b0010};
    vt[8]  = '{4'b0001, 1'b1, 4'b0001};
    vt[9]  = '{4'b0000, 1'b1, 4'b0000};
    vt[10] = '{4'b0001, 1'b1, 4'b0001};
    vt[11] = '{4'b0011, 1'b1, 4'b0010};
    vt[12] = '{4'b0100, 1'b0, 4'b0000};
    vt[13] = '{4'b1111, 1'b1, 4'b0100};
    for (int k = 0; k < NR; k++) tpz[k] = rand_puzzle();

    // Reset state.
    rst = 1;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 0;

    // Round-robin vectors: one idle-to-run cycle, then one row per cycle.
    bus.en = 1;
    for (int k = 0; k < NR; k++) bus.req_puzzle[k*PW +: PW] = tpz[k];
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      bus.req_valid = vt[i].valid;
      bus.core_read = vt[i].read;
      #3;
      exp_pz = '0;
      for (int k = 0; k < NR; k++) if (vt[i].exp_ready[k]) exp_pz = tpz[k];
      chk($sformatf("rr%0d req_ready", i), bus.req_ready, vt[i].exp_ready);
      chk($sformatf("rr%0d core_pz_in", i), bus.core_pz_in, exp_pz);
      chk($sformatf("rr%0d core_go", i), bus.core_go, 1'b1);
      @(posedge clk); #1;
    end

    // Fresh start for randomized traffic.
    rst = 1;
    drive_idle();
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    repeat (1000) step(90, 70);
    repeat (150) step(0, 80);    // drain: no grants, in-flight puzzles retire
    repeat (600) step(100, 60);
    repeat (1600) step(100, 0);  // blocked consumer: pass counters climb to saturation

    // Asynchronous reset with slots and response buffer busy.
    rst = 1;
    bus.en = 1; bus.req_valid = '1; bus.core_read = 1; bus.core_done = 0;
    #3;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst = 0;
    drive_idle();
    model_reset();
    repeat (300) step(100, 90);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
